// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered channel multiplexer with manual select and timed round-robin scan.
module chan_scan_mux #(
    parameter int WIDTH = 1,
    parameter int NCH   = 4,
    parameter int DWELL = 1,
    localparam int SW   = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in,
    input  logic [SW-1:0]        sel,
    input  logic                 load,
    input  logic                 auto_en,
    input  logic                 hold,
    output logic [WIDTH-1:0]     out,
    output logic [SW-1:0]        ch,
    output logic                 out_valid,
    output logic                 wrap
);
    localparam logic [0:0] MANUAL = 1'b0;
    localparam logic [0:0] SCAN   = 1'b1;
    logic [0:0]    st;
    logic [SW-1:0] cur_ch;
    logic [7:0]    dwell_cnt;
    logic          wrap_pend;
    logic [SW-1:0] sel_sat;
    logic [SW-1:0] nxt_ch;
    logic          last_dwell;
    assign sel_sat    = (32'(sel) >= NCH) ? SW'(NCH - 1) : sel;
    assign nxt_ch     = (cur_ch == SW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
    assign last_dwell = dwell_cnt == 8'(DWELL - 1);
    // wrap_pend bridges the one-cycle gap between cur_ch reaching 0 and ch showing it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= MANUAL;
            cur_ch    <= '0;
            dwell_cnt <= '0;
            wrap_pend <= 1'b0;
            out       <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            if (!hold) st <= auto_en ? SCAN : MANUAL;
            if (load) begin
                cur_ch    <= sel_sat;
                dwell_cnt <= '0;
                wrap_pend <= 1'b0;
            end else if (!hold) begin
                if (st == SCAN && auto_en) begin
                    cur_ch    <= last_dwell ? nxt_ch : cur_ch;
                    dwell_cnt <= last_dwell ? 8'd0 : dwell_cnt + 8'd1;
                    wrap_pend <= last_dwell && cur_ch == SW'(NCH - 1);
                end else begin
                    dwell_cnt <= '0;
                    wrap_pend <= 1'b0;
                end
            end
            if (hold) begin
                out_valid <= 1'b0;
                wrap      <= 1'b0;
            end else begin
                out       <= in[cur_ch*WIDTH +: WIDTH];
                ch        <= cur_ch;
                out_valid <= 1'b1;
                wrap      <= wrap_pend && !load;
            end
        end
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: table-driven cycle-by-cycle check of chan_scan_mux (WIDTH=4, NCH=4, DWELL=2).
module tb_chan_scan_mux;
    typedef struct {
        logic       r, l;
        logic [1:0] s;
        logic       a, h;
        logic [3:0] o;
        logic [1:0] c;
        logic       v, w;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = 16'hDCBA;
    logic [1:0]  sel = '0;
    logic        load = 1'b0, auto_en = 1'b0, hold = 1'b0;
    logic [3:0]  out;
    logic [1:0]  ch;
    logic        out_valid, wrap;
    int          tests = 0, fails = 0;
    vec_t        q[$];
    chan_scan_mux #(.WIDTH(4), .NCH(4), .DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .load(load),
        .auto_en(auto_en), .hold(hold), .out(out), .ch(ch),
        .out_valid(out_valid), .wrap(wrap)
    );
    always #5 clk = ~clk;
    task automatic add(input logic r, l, input logic [1:0] s, input logic a, h,
                       input logic [3:0] o, input logic [1:0] c, input logic v, w);
        vec_t t;
        t = '{r, l, s, a, h, o, c, v, w};
        q.push_back(t);
    endtask
    task automatic step(input logic r, l, input logic [1:0] s, input logic a, h);
        @(negedge clk);
        rst_n = r; load = l; sel = s; auto_en = a; hold = h;
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string name, input logic [3:0] o, input logic [1:0] c,
                         input logic v, input logic w);
        tests++;
        if ({out, ch, out_valid, wrap} !== {o, c, v, w}) begin
            fails++;
            $display("FAIL %s: got out=%h ch=%0d valid=%b wrap=%b, want out=%h ch=%0d valid=%b wrap=%b",
                     name, out, ch, out_valid, wrap, o, c, v, w);
        end
    endtask
    initial begin
        // r l s a h | out ch v w
        add(0,0,0,0,0, 4'h0,0,0,0);
        add(0,0,0,0,0, 4'h0,0,0,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        add(1,1,2,0,0, 4'hA,0,1,0);
        add(1,0,0,0,0, 4'hC,2,1,0);
        add(1,1,3,0,0, 4'hC,2,1,0);
        add(1,0,0,0,0, 4'hD,3,1,0);
        add(1,1,0,0,0, 4'hD,3,1,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        // scan: entry cycle, then 0,0,1,1,2,2,3,3,0,0 with wrap on first 0
        add(1,0,0,1,0, 4'hA,0,1,0);
        add(1,0,0,1,0, 4'hA,0,1,0);
        add(1,0,0,1,0, 4'hA,0,1,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        add(1,0,0,1,0, 4'hC,2,1,0);
        add(1,0,0,1,0, 4'hC,2,1,0);
        add(1,0,0,1,0, 4'hD,3,1,0);
        add(1,0,0,1,0, 4'hD,3,1,0);
        add(1,0,0,1,0, 4'hA,0,1,1);
        add(1,0,0,1,0, 4'hA,0,1,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        // hold mid-dwell on ch 1
        add(1,0,0,1,1, 4'hB,1,0,0);
        add(1,0,0,1,1, 4'hB,1,0,0);
        add(1,0,0,1,1, 4'hB,1,0,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        add(1,0,0,1,0, 4'hC,2,1,0);
        add(1,0,0,1,0, 4'hC,2,1,0);
        add(1,0,0,1,0, 4'hD,3,1,0);
        // load+hold at end of ch 3 dwell: load wins, no wrap
        add(1,1,1,1,1, 4'hD,3,0,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        add(1,0,0,1,0, 4'hB,1,1,0);
        add(1,0,0,1,0, 4'hC,2,1,0);
        // reset mid-scan on ch 2
        add(0,0,0,1,0, 4'h0,0,0,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        add(1,0,0,0,0, 4'hA,0,1,0);
        foreach (q[i]) begin
            step(q[i].r, q[i].l, q[i].s, q[i].a, q[i].h);
            check($sformatf("row%0d", i), q[i].o, q[i].c, q[i].v, q[i].w);
        end
        // live input sampling
        @(negedge clk) in = 16'h1234;
        @(posedge clk); #1;
        check("live_in0", 4'h4, 0, 1, 0);
        @(negedge clk) in = 16'h5678;
        @(posedge clk); #1;
        check("live_in1", 4'h8, 0, 1, 0);
        @(negedge clk) in = 16'hDCBA;
        // load beats a scan advance without hold
        step(1,0,0,1,0); check("adv_entry", 4'hA, 0, 1, 0);
        step(1,0,0,1,0); check("adv_dwell", 4'hA, 0, 1, 0);
        step(1,1,3,1,0); check("adv_load", 4'hA, 0, 1, 0);
        step(1,0,0,1,0); check("adv_ch3a", 4'hD, 3, 1, 0);
        step(1,0,0,1,0); check("adv_ch3b", 4'hD, 3, 1, 0);
        step(1,0,0,1,0); check("adv_wrap", 4'hA, 0, 1, 1);
        step(1,0,0,0,0); check("adv_exit", 4'hA, 0, 1, 0);
        step(1,0,0,0,0); check("manual_keep", 4'hA, 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
